imem_boot_loader: RTL and testbench

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

---
 rtl/imem_boot_loader.sv | 130 +++++++++++++
 tb/tb_imem_boot_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed big-endian byte stream, writes it word by word
// into instruction memory, and releases the core reset only after a complete load.
module imem_boot_loader #(
    parameter int ROM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error
);
    // state   | meaning
    // IDLE    | waiting for start after reset, core held in reset
    // LEN_HI  | expecting word count N[15:8]
    // LEN_LO  | expecting word count N[7:0], then range check
    // DATA    | collecting the four bytes of the current word
    // WRITE   | one-cycle memory write of the assembled word
    // DONE    | program complete, core released
    // ERR     | bad length, sticky until start or reset
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    localparam int IDX_W = $clog2(ROM_WORDS + 1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        byte_cnt;
    logic [31:0]       asm_word;
    logic [15:0]       len;
    logic              accept;
    logic              can_start;
    logic [15:0]       len_full;
    logic              len_bad;
    logic              last_word;

    assign accept    = in_valid & in_ready;
    assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign len_full  = {len[15:8], in_data};
    assign len_bad   = (len_full == 16'd0) || ({16'd0, len_full} > 32'(ROM_WORDS));
    // Full 16-bit compare so lengths above the index range can never alias.
    assign last_word = (16'(idx) == (len - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN_HI;
            S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO: if (accept) state_nxt = len_bad ? S_ERR : S_DATA;
            S_DATA:   if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
            S_WRITE:  state_nxt = last_word ? S_DONE : S_DATA;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_rst_n = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
            end
            S_ERR:   error = 1'b1;
            default: ;
        endcase
    end

    // Address and data are latched on the 4th byte so they are valid during WRITE
    // and simply hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            byte_cnt  <= 2'd0;
            asm_word  <= 32'd0;
            len       <= 16'd0;
            mem_waddr <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        idx      <= '0;
                        byte_cnt <= 2'd0;
                        asm_word <= 32'd0;
                    end
                end
                S_LEN_HI: if (accept) len[15:8] <= in_data;
                S_LEN_LO: if (accept) len[7:0]  <= in_data;
                S_DATA: begin
                    if (accept) begin
                        asm_word <= {asm_word[23:0], in_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_wdata <= {asm_word[23:0], in_data};
                            mem_waddr <= {{(30 - IDX_W){1'b0}}, idx, 2'b00};
                        end
                    end
                end
                S_WRITE: idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a stream-level model predicts every memory
// write and final status; a per-cycle monitor checks writes against it.
module tb_imem_boot_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, cpu_rst_n, busy, done, error;
    logic [31:0] mem_waddr, mem_wdata;

    imem_boot_loader #(.ROM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_we_cyc = -10;
    int busy_bad = 0;
    logic exp_ok;
    logic [7:0]  stream[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Stream-level model: N from the first two bytes, then big-endian words at 4*i.
    task automatic build_expect();
        int n;
        n = {stream[0], stream[1]};
        exp_addr.delete();
        exp_data.delete();
        exp_ok = (n != 0) && (n <= 1024);
        if (exp_ok) begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(32'(i * 4));
                exp_data.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
            end
        end
    endtask

    // Monitor: every mem_we must match the next predicted write; done must track cpu_rst_n.
    always begin
        @(posedge clk);
        cyc++;
        #2;
        if (rst_n) begin
            if (mem_we) begin
                last_we_cyc = cyc;
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_write: addr 0x%08h data 0x%08h with none expected",
                             mem_waddr, mem_wdata);
                end else begin
                    chk("write_addr", mem_waddr, exp_addr.pop_front());
                    chk("write_data", mem_wdata, exp_data.pop_front());
                end
            end
            chk("cpu_rst_n_vs_done", {31'd0, cpu_rst_n}, {31'd0, done});
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        budget = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && budget < 50) begin
            if (!busy) busy_bad++;
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: in_ready stuck at %0b, required 1", in_ready);
        end
        if (!busy) busy_bad++;
        @(negedge clk);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (!busy) busy_bad++;
            @(negedge clk);
        end
    endtask

    task automatic send_range(input int first, input int last, input int gap);
        for (int i = first; i <= last; i++)
            send_byte(stream[i], (i == stream.size() - 1) ? 0 : gap);
    endtask

    task automatic wait_end(input logic check_latency);
        int budget;
        budget = 0;
        while (!done && !error && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: done=%0b error=%0b, required one of them", done, error);
        end
        if (check_latency && exp_ok) chk("done_latency", 32'(cyc - last_we_cyc), 32'd1);
    endtask

    task automatic check_end();
        chk("end_done", {31'd0, done}, {31'd0, exp_ok});
        chk("end_error", {31'd0, error}, {31'd0, ~exp_ok});
        chk("end_cpu_rst", {31'd0, cpu_rst_n}, {31'd0, exp_ok});
        chk("end_in_ready", {31'd0, in_ready}, 32'd0);
        chk("end_pending_writes", 32'(exp_addr.size()), 32'd0);
        chk("end_busy_drop", 32'(busy_bad), 32'd0);
    endtask

    task automatic run_load(input int gap, input logic check_latency);
        build_expect();
        busy_bad = 0;
        pulse_start();
        send_range(0, stream.size() - 1, gap);
        wait_end(check_latency);
        check_end();
    endtask

    task automatic set_basic();
        stream = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_waddr"}, mem_waddr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpu_rst"}, {31'd0, cpu_rst_n}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);

        // basic load
        set_basic();
        run_load(0, 1'b1);
        chk("basic_hold_addr", mem_waddr, 32'h0000_0004);
        chk("basic_hold_data", mem_wdata, 32'hAC08_0000);

        // stalled source
        set_basic();
        run_load(3, 1'b0);
        chk("stall_hold_data", mem_wdata, 32'hAC08_0000);

        // bad lengths, sticky error, then recovery
        stream = {8'h00, 8'h00};
        run_load(0, 1'b0);
        repeat (3) @(negedge clk);
        chk("err_sticky", {31'd0, error}, 32'd1);
        stream = {8'h04, 8'h01};
        run_load(0, 1'b0);
        chk("err_1025", {31'd0, error}, 32'd1);
        set_basic();
        run_load(0, 1'b0);
        chk("recover_done", {31'd0, done}, 32'd1);

        // full depth, word index as data
        stream = {8'h04, 8'h00};
        for (int i = 0; i < 1024; i++) begin
            stream.push_back(8'(i >> 24));
            stream.push_back(8'(i >> 16));
            stream.push_back(8'(i >> 8));
            stream.push_back(8'(i));
        end
        run_load(0, 1'b1);
        chk("full_last_addr", mem_waddr, 32'h0000_0FFC);
        chk("full_last_data", mem_wdata, 32'h0000_03FF);

        // reset after 2nd data byte
        set_basic();
        build_expect();
        pulse_start();
        send_range(0, 3, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
        chk("midrst_idle_cpu", {31'd0, cpu_rst_n}, 32'd0);
        set_basic();
        run_load(0, 1'b1);
        chk("midrst_reload_addr", mem_waddr, 32'h0000_0004);

        // start during DATA is ignored
        set_basic();
        build_expect();
        busy_bad = 0;
        pulse_start();
        send_range(0, 2, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ready", {31'd0, in_ready}, 32'd1);
        send_range(3, stream.size() - 1, 0);
        wait_end(1'b0);
        check_end();

        // start in DONE triggers a reload from word 0
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reload_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
        chk("reload_done", {31'd0, done}, 32'd0);
        set_basic();
        run_load(0, 1'b1);
        chk("reload_final_data", mem_wdata, 32'hAC08_0000);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
